tictactoe_qlearn_top: RTL and testbench

- Top level of the tic-tac-toe Q-learning engine. Holds the 18-bit board state and picks the agent move as the argmax of nine externally supplied Q-values. Applies the user move, computes the Q-learning update, and pulses one of nine per-action RAM write enables.
- Q-RAM storage lives outside the block. It is addressed by state_output_software.

---
 rtl/tictactoe_qlearn_top.sv | 208 ++++++++++++++++++++
 tb/tb_tictactoe_qlearn_top.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tictactoe_qlearn_top.sv
// Tic-tac-toe Q-learning engine: holds the board, picks the agent move from externally
// supplied Q-values, applies the user move and produces one Q-learning update per move.
module tictactoe_qlearn_top #(
    parameter int                 ALPHA_SHIFT = 1,
    parameter int                 GAMMA_SHIFT = 1,
    parameter logic signed [15:0] R_WIN       = 16'sd100,
    parameter logic signed [15:0] R_LOSE      = -16'sd100,
    parameter logic signed [15:0] R_DRAW      = 16'sd0,
    parameter logic [15:0]        TRAIN_GAMES = 16'd1000
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic signed [15:0] Q_value_act1,
    input  logic signed [15:0] Q_value_act2,
    input  logic signed [15:0] Q_value_act3,
    input  logic signed [15:0] Q_value_act4,
    input  logic signed [15:0] Q_value_act5,
    input  logic signed [15:0] Q_value_act6,
    input  logic signed [15:0] Q_value_act7,
    input  logic signed [15:0] Q_value_act8,
    input  logic signed [15:0] Q_value_act9,
    input  logic [3:0]         user_action,
    input  logic               enable_cu,
    output logic [17:0]        state_output_software,
    output logic signed [15:0] Q_new,
    output logic               training_flag,
    output logic               en_ram1,
    output logic               en_ram2,
    output logic               en_ram3,
    output logic               en_ram4,
    output logic               en_ram5,
    output logic               en_ram6,
    output logic               en_ram7,
    output logic               en_ram8,
    output logic               en_ram9,
    output logic [17:0]        state_plus1,
    output logic [17:0]        state,
    output logic [15:0]        counter
);

    typedef enum logic [2:0] {IDLE, SELECT, AGENT, USER, NEXTQ, UPDATE} fsm_t;

    fsm_t               cur_state, nxt_state;
    logic signed [15:0] q_in [9];
    logic [8:0]         en_ram;
    logic [3:0]         act;
    logic signed [15:0] q_sa, reward;
    logic               terminal;
    logic [8:0]         scan_empty;
    logic               scan_found;
    logic [3:0]         best_idx;
    logic signed [15:0] best_val;
    logic [17:0]        agent_board, user_board;
    logic [8:0]         plus1_empty;
    logic [3:0]         user_idx;
    logic               user_ok;
    logic signed [15:0] max_next, q_upd;
    logic signed [17:0] qsa_ext, max_ext, r_ext, diff, sum;

    function automatic logic [8:0] cells_of(input logic [17:0] b, input logic [1:0] who);
        logic [8:0] m;
        for (int i = 0; i < 9; i++) m[i] = (b[2*i +: 2] == who);
        return m;
    endfunction

    function automatic logic has_line(input logic [8:0] m);
        return ((m & 9'h007) == 9'h007) || ((m & 9'h038) == 9'h038) ||
               ((m & 9'h1C0) == 9'h1C0) || ((m & 9'h049) == 9'h049) ||
               ((m & 9'h092) == 9'h092) || ((m & 9'h124) == 9'h124) ||
               ((m & 9'h111) == 9'h111) || ((m & 9'h054) == 9'h054);
    endfunction

    assign q_in[0] = Q_value_act1;
    assign q_in[1] = Q_value_act2;
    assign q_in[2] = Q_value_act3;
    assign q_in[3] = Q_value_act4;
    assign q_in[4] = Q_value_act5;
    assign q_in[5] = Q_value_act6;
    assign q_in[6] = Q_value_act7;
    assign q_in[7] = Q_value_act8;
    assign q_in[8] = Q_value_act9;

    assign {en_ram9, en_ram8, en_ram7, en_ram6, en_ram5,
            en_ram4, en_ram3, en_ram2, en_ram1} = en_ram;

    assign training_flag = (counter < TRAIN_GAMES);

    // The RAM sees the next board only while its best follow-up value is being read
    assign state_output_software = (cur_state == NEXTQ) ? state_plus1 : state;

    // One scanner serves both the argmax in SELECT and the max in NEXTQ; strict > keeps the lowest cell on ties
    always_comb begin
        scan_empty = cells_of(state_output_software, 2'b00);
        scan_found = 1'b0;
        best_idx   = '0;
        best_val   = '0;
        for (int i = 0; i < 9; i++) begin
            if (scan_empty[i] && (!scan_found || q_in[i] > best_val)) begin
                scan_found = 1'b1;
                best_idx   = 4'(i);
                best_val   = q_in[i];
            end
        end
    end

    always_comb begin
        agent_board = state | (18'd1 << {act, 1'b0});
        plus1_empty = cells_of(state_plus1, 2'b00);
        user_idx    = user_action - 4'd1;
        user_ok     = !terminal && (user_action != 4'd0) && (user_action <= 4'd9) &&
                      plus1_empty[user_idx];
        user_board  = user_ok ? (state_plus1 | (18'd2 << {user_idx, 1'b0})) : state_plus1;
    end

    always_comb begin
        max_next = (terminal || !scan_found) ? 16'sd0 : best_val;
        qsa_ext  = {{2{q_sa[15]}}, q_sa};
        max_ext  = {{2{max_next[15]}}, max_next};
        r_ext    = {{2{reward[15]}}, reward};
        diff     = r_ext + (max_ext >>> GAMMA_SHIFT) - qsa_ext;
        sum      = qsa_ext + (diff >>> ALPHA_SHIFT);
        if (sum > 18'sd32767)
            q_upd = 16'sh7FFF;
        else if (sum < -18'sd32768)
            q_upd = 16'sh8000;
        else
            q_upd = sum[15:0];
    end

    always_comb begin
        nxt_state = cur_state;
        case (cur_state)
            IDLE:    if (enable_cu) nxt_state = SELECT;
            SELECT:  nxt_state = scan_found ? AGENT : UPDATE;
            AGENT:   nxt_state = USER;
            USER:    nxt_state = NEXTQ;
            NEXTQ:   nxt_state = UPDATE;
            UPDATE:  nxt_state = enable_cu ? SELECT : IDLE;
            default: nxt_state = IDLE;
        endcase
    end

    // Q_new and the write strobe are loaded on entry to UPDATE so they coincide with the state address
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cur_state   <= IDLE;
            state       <= '0;
            state_plus1 <= '0;
            Q_new       <= '0;
            counter     <= '0;
            en_ram      <= '0;
            act         <= '0;
            q_sa        <= '0;
            reward      <= '0;
            terminal    <= 1'b0;
        end else begin
            cur_state <= nxt_state;
            en_ram    <= '0;
            case (cur_state)
                SELECT: begin
                    reward <= R_DRAW;
                    if (scan_found) begin
                        terminal <= 1'b0;
                        act      <= best_idx;
                        q_sa     <= best_val;
                    end else begin
                        terminal <= 1'b1;
                        q_sa     <= '0;
                    end
                end
                AGENT: begin
                    state_plus1 <= agent_board;
                    if (has_line(cells_of(agent_board, 2'b01))) begin
                        terminal <= 1'b1;
                        reward   <= R_WIN;
                    end
                end
                USER: begin
                    if (!terminal) begin
                        state_plus1 <= user_board;
                        if (has_line(cells_of(user_board, 2'b10))) begin
                            terminal <= 1'b1;
                            reward   <= R_LOSE;
                        end else if (cells_of(user_board, 2'b00) == 9'd0) begin
                            terminal <= 1'b1;
                            reward   <= R_DRAW;
                        end
                    end
                end
                NEXTQ: begin
                    Q_new <= q_upd;
                    if (training_flag) en_ram <= 9'd1 << act;
                end
                UPDATE: begin
                    if (terminal) begin
                        state       <= '0;
                        state_plus1 <= '0;
                        if (counter != 16'hFFFF) counter <= counter + 16'd1;
                    end else begin
                        state <= state_plus1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_tictactoe_qlearn_top.sv
// Scoreboard bench: a cell-array game model predicts each UPDATE; a monitor compares at that cycle.
module tb_tictactoe_qlearn_top;

    localparam logic [15:0] TRAIN = 16'd10;
    localparam int          ALPHA = 1;
    localparam int          GAMMA = 1;

    typedef int board_t [9];

    typedef struct {
        int                 upd_cyc;
        logic [8:0]         en;
        logic signed [15:0] qnew;
        logic               tflag;
        logic [17:0]        addr;
        logic [17:0]        sp1;
        logic [17:0]        st_after;
        logic [17:0]        sp1_after;
        logic [15:0]        cnt_after;
    } exp_t;

    logic               clock;
    logic               reset_n;
    logic signed [15:0] qv [9];
    logic [3:0]         user_action;
    logic               enable_cu;
    logic [17:0]        state_output_software;
    logic signed [15:0] Q_new;
    logic               training_flag;
    logic               en_ram1, en_ram2, en_ram3, en_ram4, en_ram5;
    logic               en_ram6, en_ram7, en_ram8, en_ram9;
    logic [17:0]        state_plus1;
    logic [17:0]        state;
    logic [15:0]        counter;

    logic               q_mode;
    logic [31:0]        q_seed;
    int                 q_shift;
    logic signed [15:0] q_const [9];

    board_t             mb;
    int                 mcnt;
    logic signed [15:0] last_q;
    logic [17:0]        m_sp1;

    exp_t               sbq [$];
    int                 cyc = 0;
    int                 n_vec = 0;
    int                 n_bad = 0;

    tictactoe_qlearn_top #(.TRAIN_GAMES(TRAIN)) dut (
        .clock(clock), .reset_n(reset_n),
        .Q_value_act1(qv[0]), .Q_value_act2(qv[1]), .Q_value_act3(qv[2]),
        .Q_value_act4(qv[3]), .Q_value_act5(qv[4]), .Q_value_act6(qv[5]),
        .Q_value_act7(qv[6]), .Q_value_act8(qv[7]), .Q_value_act9(qv[8]),
        .user_action(user_action), .enable_cu(enable_cu),
        .state_output_software(state_output_software), .Q_new(Q_new),
        .training_flag(training_flag),
        .en_ram1(en_ram1), .en_ram2(en_ram2), .en_ram3(en_ram3),
        .en_ram4(en_ram4), .en_ram5(en_ram5), .en_ram6(en_ram6),
        .en_ram7(en_ram7), .en_ram8(en_ram8), .en_ram9(en_ram9),
        .state_plus1(state_plus1), .state(state), .counter(counter)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    // Stand-in for the external Q-RAM: a fixed pseudo-random value per (board, action)
    function automatic logic signed [15:0] q_for(input logic [17:0] st, input int k,
                                                 input logic [31:0] seed, input int sh);
        logic [31:0] h;
        h = {14'd0, st} * 32'd2654435761 + 32'(k) * 32'd40503 + seed;
        h = h ^ (h >> 13);
        h = h * 32'h5bd1e995;
        h = h ^ (h >> 15);
        return $signed(h[15:0]) >>> sh;
    endfunction

    always_comb begin
        for (int k = 0; k < 9; k++)
            qv[k] = q_mode ? q_for(state_output_software, k + 1, q_seed, q_shift) : q_const[k];
    end

    function automatic logic [17:0] enc(input board_t b);
        logic [17:0] r;
        for (int k = 0; k < 9; k++) r[2*k +: 2] = 2'(b[k]);
        return r;
    endfunction

    function automatic int mq(input logic [17:0] st, input int k0);
        return q_mode ? int'(q_for(st, k0 + 1, q_seed, q_shift)) : int'(q_const[k0]);
    endfunction

    function automatic bit owns_line(input board_t b, input int who);
        bit hit;
        hit = 0;
        for (int i = 0; i < 3; i++) begin
            if (b[3*i] == who && b[3*i+1] == who && b[3*i+2] == who) hit = 1;
            if (b[i] == who && b[i+3] == who && b[i+6] == who) hit = 1;
        end
        if (b[0] == who && b[4] == who && b[8] == who) hit = 1;
        if (b[2] == who && b[4] == who && b[6] == who) hit = 1;
        return hit;
    endfunction

    function automatic bit is_full(input board_t b);
        bit f;
        f = 1;
        for (int k = 0; k < 9; k++) if (b[k] == 0) f = 0;
        return f;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_bad++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, got, want);
        end
    endtask

    task automatic model_reset();
        mb     = '{default: 0};
        mcnt   = 0;
        last_q = '0;
        m_sp1  = '0;
    endtask

    // Plays one move of the game by the rules and records what the UPDATE cycle must show
    task automatic model_step(input int user, output exp_t e);
        board_t      b, nb;
        logic [17:0] e_old;
        int          best, bestv, qsa, r, maxq, v, qn;
        bit          term, found;
        b      = mb;
        e_old  = enc(b);
        e.tflag = (mcnt < int'(TRAIN));
        e.addr  = e_old;
        best = -1;
        bestv = 0;
        for (int k = 0; k < 9; k++) begin
            if (b[k] == 0) begin
                v = mq(e_old, k);
                if (best < 0 || v > bestv) begin best = k; bestv = v; end
            end
        end
        nb = b;
        term = 0;
        r = 0;
        if (best < 0) begin
            term = 1;
            e.en = '0;
            e.qnew = last_q;
            e.sp1 = m_sp1;
        end else begin
            qsa = bestv;
            nb[best] = 1;
            if (owns_line(nb, 1)) begin
                term = 1;
                r = 100;
            end else begin
                if (user >= 1 && user <= 9 && nb[user-1] == 0) nb[user-1] = 2;
                if (owns_line(nb, 2)) begin
                    term = 1;
                    r = -100;
                end else if (is_full(nb)) begin
                    term = 1;
                end
            end
            maxq = 0;
            if (!term) begin
                found = 0;
                for (int k = 0; k < 9; k++) begin
                    if (nb[k] == 0) begin
                        v = mq(enc(nb), k);
                        if (!found || v > maxq) begin maxq = v; found = 1; end
                    end
                end
            end
            qn = qsa + ((r + (maxq >>> GAMMA) - qsa) >>> ALPHA);
            if (qn > 32767) qn = 32767;
            if (qn < -32768) qn = -32768;
            e.qnew = 16'(qn);
            last_q = e.qnew;
            e.en = e.tflag ? (9'd1 << best) : 9'd0;
            e.sp1 = enc(nb);
        end
        if (term) begin
            mb = '{default: 0};
            if (mcnt < 65535) mcnt++;
            e.st_after = '0;
            e.sp1_after = '0;
        end else begin
            mb = nb;
            e.st_after = enc(nb);
            e.sp1_after = enc(nb);
        end
        m_sp1 = e.sp1_after;
        e.cnt_after = 16'(mcnt);
    endtask

    // Called at a falling edge with the DUT in IDLE, or in UPDATE when the previous move chained
    task automatic apply_move(input int user, input bit chain);
        exp_t e;
        model_step(user, e);
        e.upd_cyc = cyc + 5;
        sbq.push_back(e);
        user_action = 4'(user);
        enable_cu = 1'b1;
        repeat (4) @(negedge clock);
        enable_cu = chain;
        @(negedge clock);
        if (!chain) @(negedge clock);
    endtask

    exp_t       post_exp;
    bit         post_pending = 0;
    exp_t       mon_e;
    logic [8:0] en_now;

    always @(negedge clock) begin
        en_now = {en_ram9, en_ram8, en_ram7, en_ram6, en_ram5, en_ram4, en_ram3, en_ram2, en_ram1};
        if (post_pending) begin
            post_pending = 0;
            check("state_after", 32'(state), 32'(post_exp.st_after));
            check("plus1_after", 32'(state_plus1), 32'(post_exp.sp1_after));
            check("counter_after", 32'(counter), 32'(post_exp.cnt_after));
        end
        if (sbq.size() > 0 && sbq[0].upd_cyc == cyc) begin
            mon_e = sbq.pop_front();
            check("en_ram", 32'(en_now), 32'(mon_e.en));
            check("q_new", 32'(Q_new), 32'(mon_e.qnew));
            check("training_flag", 32'(training_flag), 32'(mon_e.tflag));
            check("ram_addr", 32'(state_output_software), 32'(mon_e.addr));
            check("state_plus1", 32'(state_plus1), 32'(mon_e.sp1));
            post_exp = mon_e;
            post_pending = 1;
        end else if (en_now != 9'd0) begin
            check("stray_en_ram", 32'(en_now), 32'd0);
        end
    end

    initial begin
        bit last_chain;
        int u;
        reset_n = 1'b0;
        enable_cu = 1'b0;
        user_action = '0;
        q_mode = 1'b0;
        q_seed = '0;
        q_shift = 0;
        for (int k = 0; k < 9; k++) q_const[k] = '0;
        model_reset();
        repeat (2) @(negedge clock);
        check("rst_state", 32'(state), 32'd0);
        check("rst_plus1", 32'(state_plus1), 32'd0);
        check("rst_qnew", 32'(Q_new), 32'd0);
        check("rst_counter", 32'(counter), 32'd0);
        check("rst_addr", 32'(state_output_software), 32'd0);
        check("rst_tflag", 32'(training_flag), 32'(mcnt < int'(TRAIN)));
        reset_n = 1'b1;
        @(negedge clock);

        q_const = '{16'sd12, 16'sd10, 16'sd13, 16'sd17, 16'sd18, 16'sd32, 16'sd62, 16'sd8, 16'sd1};
        apply_move(2, 0);
        check("first_qnew", 32'(Q_new), 32'(16'sd39));
        check("first_state", 32'(state), 32'h01008);

        repeat (10) @(negedge clock);
        check("hold_state", 32'(state), 32'(enc(mb)));
        check("hold_counter", 32'(counter), 32'(mcnt));

        for (int k = 0; k < 9; k++) q_const[k] = '0;
        apply_move(7, 0);

        // Abandon a move halfway: outputs must drop without waiting for a clock edge
        user_action = 4'd3;
        enable_cu = 1'b1;
        repeat (2) @(negedge clock);
        #2 reset_n = 1'b0;
        #1;
        enable_cu = 1'b0;
        check("async_state", 32'(state), 32'd0);
        check("async_plus1", 32'(state_plus1), 32'd0);
        check("async_qnew", 32'(Q_new), 32'd0);
        check("async_counter", 32'(counter), 32'd0);
        check("async_addr", 32'(state_output_software), 32'd0);
        model_reset();
        sbq.delete();
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);

        for (int k = 0; k < 9; k++) q_const[k] = '0;
        q_const[0] = 16'sd50;
        apply_move(9, 0);
        for (int k = 0; k < 9; k++) q_const[k] = '0;
        q_const[1] = 16'sd50;
        apply_move(5, 0);
        for (int k = 0; k < 9; k++) q_const[k] = '0;
        q_const[2] = 16'sd20;
        apply_move(4, 0);
        check("win_qnew", 32'(Q_new), 32'(16'sd60));
        check("win_state", 32'(state), 32'd0);
        check("win_counter", 32'(counter), 32'(mcnt));

        q_mode = 1'b1;
        last_chain = 0;
        for (int m = 0; m < 400 && (mcnt < int'(TRAIN) + 3 || m < 60); m++) begin
            if (enc(mb) == 18'd0) begin
                q_seed = $urandom();
                q_shift = $urandom_range(0, 12);
            end
            if ($urandom_range(0, 4) != 0) u = $urandom_range(1, 9);
            else u = $urandom_range(0, 15);
            last_chain = bit'($urandom_range(0, 1));
            apply_move(u, last_chain);
        end
        if (last_chain) apply_move(0, 0);
        check("training_off", 32'(training_flag), 32'(mcnt < int'(TRAIN)));

        for (int w = 0; w < 20 && sbq.size() > 0; w++) @(negedge clock);
        if (sbq.size() > 0) check("scoreboard_drain", 32'(sbq.size()), 32'd0);
        repeat (2) @(negedge clock);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
